// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - mole position/timing generator for the whack-a-mole game FSM
module mole_spawner #(
    parameter int          TICK_DIV  = 100000,
    parameter int          GAP_MS    = 250,
    parameter int          EASY_MS   = 3000,
    parameter int          MED_MS    = 2000,
    parameter int          HARD_MS   = 1000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] difficulty,
    input  logic       hit,
    output logic       mole_valid,
    output logic [3:0] mole_pos,
    output logic [8:0] mole_onehot,
    output logic       spawn_pulse,
    output logic       expire_pulse,
    output logic [6:0] miss_count,
    output logic       busy
);

    localparam logic [31:0] GAP_CYC  = 32'(GAP_MS * TICK_DIV);
    localparam logic [31:0] EASY_CYC = 32'(EASY_MS * TICK_DIV);
    localparam logic [31:0] MED_CYC  = 32'(MED_MS * TICK_DIV);
    localparam logic [31:0] HARD_CYC = 32'(HARD_MS * TICK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP} state_t;

    state_t      state;
    logic [31:0] timer;
    logic [1:0]  diff_q;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [3:0]  prev_pos;
    logic [31:0] life;
    logic [3:0]  raw_pos;
    logic [3:0]  next_pos;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);

    always_comb begin
        case (diff_q)
            2'b00:   life = EASY_CYC;
            2'b01:   life = MED_CYC;
            default: life = HARD_CYC;
        endcase
    end

    // Fold 9..15 back into 0..6, then step past the previous hole
    always_comb begin
        raw_pos = lfsr[3:0];
        if (raw_pos > 4'd8)
            raw_pos = raw_pos - 4'd9;
        next_pos = raw_pos;
        if (raw_pos == prev_pos)
            next_pos = (raw_pos == 4'd8) ? 4'd0 : raw_pos + 4'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            timer        <= 32'd0;
            diff_q       <= 2'b00;
            lfsr         <= LFSR_SEED;
            prev_pos     <= 4'hF;
            mole_valid   <= 1'b0;
            mole_pos     <= 4'd0;
            spawn_pulse  <= 1'b0;
            expire_pulse <= 1'b0;
            miss_count   <= 7'd0;
        end else begin
            lfsr         <= lfsr_next;
            spawn_pulse  <= 1'b0;
            expire_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        diff_q     <= difficulty;
                        miss_count <= 7'd0;
                        prev_pos   <= 4'hF;
                        timer      <= GAP_CYC - 32'd1;
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (timer == 32'd0) begin
                        mole_pos    <= next_pos;
                        prev_pos    <= next_pos;
                        mole_valid  <= 1'b1;
                        spawn_pulse <= 1'b1;
                        timer       <= life - 32'd1;
                        state       <= S_UP;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                S_UP: begin
                    if (stop) begin
                        mole_valid <= 1'b0;
                        state      <= S_IDLE;
                    end else if (hit) begin
                        mole_valid <= 1'b0;
                        timer      <= GAP_CYC - 32'd1;
                        state      <= S_GAP;
                    end else if (timer == 32'd0) begin
                        mole_valid   <= 1'b0;
                        expire_pulse <= 1'b1;
                        if (miss_count != 7'd127)
                            miss_count <= miss_count + 7'd1;
                        timer <= GAP_CYC - 32'd1;
                        state <= S_GAP;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign mole_onehot = mole_valid ? (9'd1 << mole_pos) : 9'd0;

endmodule

// File: tb/tb_mole_spawner.sv
// tb/tb_mole_spawner.sv - scoreboard bench for mole_spawner
module tb_mole_spawner;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] difficulty = 2'b00;
    logic       hit = 1'b0;
    logic       mole_valid;
    logic [3:0] mole_pos;
    logic [8:0] mole_onehot;
    logic       spawn_pulse;
    logic       expire_pulse;
    logic [6:0] miss_count;
    logic       busy;

    mole_spawner #(
        .TICK_DIV(4), .GAP_MS(2), .EASY_MS(6), .MED_MS(4), .HARD_MS(2), .LFSR_SEED(16'hACE1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .stop(stop), .difficulty(difficulty),
        .hit(hit), .mole_valid(mole_valid), .mole_pos(mole_pos), .mole_onehot(mole_onehot),
        .spawn_pulse(spawn_pulse), .expire_pulse(expire_pulse), .miss_count(miss_count),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int   kind;   // 0 = mole rises, 1 = mole falls
        int   cyc;
        logic expire;
        int   miss;
        logic busy;
    } ev_t;

    ev_t  q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   g;
    int   exp_miss;
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_prev;
    logic [3:0]  prev_m = 4'hF;
    logic        mv_q = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference LFSR: the mole is placed from the value held just before the spawn edge
    always @(posedge Clk) begin
        cyc       <= cyc + 1;
        lfsr_prev <= lfsr_m;
        if (Reset)
            lfsr_m <= 16'hACE1;
        else
            lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end

    always @(negedge Clk) begin
        logic rise, fall;
        logic [3:0] c;
        ev_t e;
        rise = mole_valid && !mv_q;
        fall = !mole_valid && mv_q;
        chk("spawn_vs_rise", spawn_pulse, rise);
        if (expire_pulse && !fall)
            chk("expire_without_fall", 1, 0);
        if (rise || fall) begin
            if (q.size() == 0) begin
                chk("unexpected_event", rise ? 0 : 1, 99);
            end else begin
                e = q.pop_front();
                chk(rise ? "rise_kind" : "fall_kind", rise ? 0 : 1, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (rise) begin
                    c = lfsr_prev[3:0];
                    if (c > 4'd8) c = c - 4'd9;
                    if (c == prev_m) c = (c == 4'd8) ? 4'd0 : c + 4'd1;
                    chk("mole_pos", mole_pos, c);
                    chk("pos_range", mole_pos <= 4'd8, 1);
                    chk("no_repeat", mole_pos != prev_m, 1);
                    chk("onehot_up", mole_onehot, 9'd1 << c);
                    prev_m = mole_pos;
                end else begin
                    chk("expire_pulse", expire_pulse, e.expire);
                    chk("miss_count", miss_count, e.miss);
                    chk("busy_after_end", busy, e.busy);
                    chk("onehot_down", mole_onehot, 0);
                end
            end
        end
        mv_q = mole_valid;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge Clk);
    endtask

    task automatic push(input int kind, input int c, input logic ex, input int m, input logic b);
        ev_t e;
        e.kind = kind; e.cyc = c; e.expire = ex; e.miss = m; e.busy = b;
        q.push_back(e);
    endtask

    task automatic do_start(input logic [1:0] d);
        start = 1'b1;
        difficulty = d;
        prev_m = 4'hF;
        @(negedge Clk);
        start = 1'b0;
        g = cyc;
        exp_miss = 0;
        chk("miss_clear_on_start", miss_count, 0);
        chk("busy_on_start", busy, 1);
    endtask

    // One gap + mole window. hitk/stopk/rstk: UP cycle (1-based) of that action, 0 = none
    task automatic mole(input int life, input int hitk, input int stopk, input int rstk, input bit noise);
        int s, e;
        s = g + 8;
        push(0, s, 1'b0, 0, 1'b1);
        if (noise) begin
            wait_cyc(g + 2);
            hit = 1'b1; start = 1'b1; difficulty = 2'b00;
            @(negedge Clk);
            hit = 1'b0; start = 1'b0;
        end
        if (rstk > 0) begin
            e = s + rstk;
            push(1, e, 1'b0, 0, 1'b0);
            wait_cyc(e - 1);
            Reset = 1'b1;
            @(negedge Clk);
            chk("rst_valid", mole_valid, 0);
            chk("rst_pos", mole_pos, 0);
            chk("rst_onehot", mole_onehot, 0);
            chk("rst_spawn", spawn_pulse, 0);
            chk("rst_expire", expire_pulse, 0);
            chk("rst_busy", busy, 0);
            chk("rst_lfsr", dut.lfsr, 16'hACE1);
            Reset = 1'b0;
            prev_m = 4'hF;
        end else if (stopk > 0) begin
            e = s + stopk;
            push(1, e, 1'b0, exp_miss, 1'b0);
            wait_cyc(e - 1);
            stop = 1'b1;
            @(negedge Clk);
            stop = 1'b0;
        end else if (hitk > 0) begin
            e = s + hitk;
            push(1, e, 1'b0, exp_miss, 1'b1);
            wait_cyc(e - 1);
            hit = 1'b1;
            @(negedge Clk);
            hit = 1'b0;
            g = e;
        end else begin
            e = s + life;
            if (exp_miss < 127) exp_miss++;
            push(1, e, 1'b1, exp_miss, 1'b1);
            wait_cyc(e);
            g = e;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset_valid", mole_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_miss", miss_count, 0);
        chk("reset_onehot", mole_onehot, 0);
        chk("reset_lfsr", dut.lfsr, 16'hACE1);
        Reset = 1'b0;
        @(negedge Clk);

        // Easy, unhit moles with ignored hit/start/difficulty noise in the gap
        do_start(2'b00);
        mole(24, 0, 0, 0, 1);
        mole(24, 0, 0, 0, 0);
        mole(24, 0, 5, 0, 0);
        repeat (4) @(negedge Clk);
        chk("miss_held_after_stop", miss_count, 2);
        chk("idle_after_stop", busy, 0);

        // Hard: hit on third UP cycle, then a timeout
        do_start(2'b10);
        mole(8, 3, 0, 0, 1);
        mole(8, 0, 0, 0, 0);
        mole(8, 0, 2, 0, 0);

        // Difficulty 11: hit on the final UP cycle beats the timeout
        do_start(2'b11);
        mole(8, 8, 0, 0, 0);
        mole(8, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0)
                mole(8, $urandom_range(1, 8), 0, 0, 0);
            else
                mole(8, 0, 0, 0, 0);
        end
        mole(8, 0, 4, 0, 0);

        // Start and stop together stay idle
        start = 1'b1; stop = 1'b1;
        @(negedge Clk);
        start = 1'b0; stop = 1'b0;
        repeat (12) @(negedge Clk);
        chk("start_stop_idle", busy, 0);
        chk("start_stop_novalid", mole_valid, 0);

        // Medium window, then reset during UP
        do_start(2'b01);
        mole(16, 0, 0, 0, 0);
        mole(16, 0, 0, 5, 0);
        repeat (12) @(negedge Clk);
        chk("queue_empty", q.size(), 0);
        chk("idle_after_reset", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
